cmd_encoder: RTL and testbench

Transmit-side counterpart of the Decoder. Packs one control command (on/off/increase/decrease/send/receive plus DAC amount) into a 32-bit word in the command word format shared with Decoder, buffers it, and presents it on a valid/ready stream toward the AXI transmit path. Sits between the local control logic and the AXI write/stream interface of the Zynq PS side.

---
 rtl/cmd_encoder_pkg.sv | 45 ++++
 rtl/cmd_fifo.sv | 64 ++++++
 rtl/cmd_encoder.sv | 167 ++++++++++++++++
 tb/tb_cmd_encoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_encoder_pkg.sv
// Command word definitions shared by the transmit-side encoder and the Decoder.
// Both ends use this package so the opcode values, field positions and checksum
// rule exist in exactly one place.
//
// Word layout (32 bits):
//   [31:28] opcode  [27:20] amount  [19:16] seq  [15:8] reserved (0)  [7:0] checksum
//   checksum = byte3 ^ byte2 ^ byte1
package cmd_encoder_pkg;

    localparam int unsigned CmdWordWidth = 32;

    localparam int unsigned OpcodeLsb = 28;
    localparam int unsigned AmountLsb = 20;
    localparam int unsigned SeqLsb    = 16;
    localparam int unsigned RsvdLsb   = 8;
    localparam int unsigned CksumLsb  = 0;

    typedef enum logic [3:0] {
        OpNone = 4'h0,
        OpOn   = 4'h1,
        OpOff  = 4'h2,
        OpInc  = 4'h3,
        OpDec  = 4'h4,
        OpSend = 4'h5,
        OpRecv = 4'h6
    } opcode_e;

    function automatic logic [7:0] calc_checksum(input logic [CmdWordWidth-1:0] word);
        return word[31:24] ^ word[23:16] ^ word[15:8];
    endfunction

    function automatic logic [CmdWordWidth-1:0] pack_cmd(input opcode_e    op,
                                                         input logic [7:0] amount,
                                                         input logic [3:0] seq);
        logic [CmdWordWidth-1:0] word;
        word                  = '0;
        word[OpcodeLsb +: 4]  = op;
        word[AmountLsb +: 8]  = amount;
        word[SeqLsb +: 4]     = seq;
        word[RsvdLsb +: 8]    = 8'h00;
        word[CksumLsb +: 8]   = calc_checksum(word);
        return word;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for encoded command words.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write strobe and data (ignored while full)
//   pop             read strobe (ignored while empty); rdata shows the head word
//   full, empty     occupancy flags
// Simultaneous push and pop both take effect, leaving occupancy unchanged.
module cmd_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("cmd_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AddrW:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW:0] rd_ptr_q, rd_ptr_d;
    logic           do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AddrW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cmd_encoder.sv
// Transmit-side command encoder. Validates the command strobes, packs one command
// into a 32-bit word, buffers it in cmd_fifo and presents it on a valid/ready stream.
// Ports:
//   clk, rst_n                                  clock, asynchronous active-low reset
//   cmd_valid, cmd_ready                        command handshake (ready = FIFO not full)
//   on, off, increase, decrease, send, receive  command strobes, exactly one expected
//   amount                                      DAC amount, zero-extended into the word
//   cmd_err                                     one-cycle pulse after a malformed command
//   tx_data, tx_valid, tx_ready                 encoded word stream
//   seq                                         sequence number of the next accepted command
module cmd_encoder
    import cmd_encoder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned AMOUNT_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    on,
    input  logic                    off,
    input  logic                    increase,
    input  logic                    decrease,
    input  logic                    send,
    input  logic                    receive,
    input  logic [AMOUNT_WIDTH-1:0] amount,
    output logic                    cmd_err,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [3:0]              seq
);

    if (DATA_WIDTH != CmdWordWidth) begin : g_width_check
        $error("cmd_encoder: DATA_WIDTH must be 32");
    end
    if (AMOUNT_WIDTH < 1 || AMOUNT_WIDTH > 8) begin : g_amount_check
        $error("cmd_encoder: AMOUNT_WIDTH must be in 1..8");
    end

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    logic [5:0]            strobes;
    logic                  one_hot;
    logic                  accept;
    logic                  push;
    opcode_e               op;
    logic [7:0]            amount_ext;
    logic [DATA_WIDTH-1:0] word;

    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic                  state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [3:0]            seq_q, seq_d;
    logic                  err_q, err_d;

    // ---------------------------------------------------------------------------
    // Strobe validation and encoding
    // ---------------------------------------------------------------------------
    assign strobes = {receive, send, decrease, increase, off, on};
    assign one_hot = $onehot(strobes);
    assign accept  = cmd_valid && cmd_ready;
    assign push    = accept && one_hot;

    always_comb begin
        op = OpNone;
        unique case (strobes)
            6'b000001: op = OpOn;
            6'b000010: op = OpOff;
            6'b000100: op = OpInc;
            6'b001000: op = OpDec;
            6'b010000: op = OpSend;
            6'b100000: op = OpRecv;
            default:   op = OpNone;
        endcase
    end

    always_comb begin
        amount_ext                   = '0;
        amount_ext[AMOUNT_WIDTH-1:0] = amount;
    end

    assign word = pack_cmd(op, amount_ext, seq_q);

    always_comb begin
        seq_d = seq_q;
        if (push) seq_d = seq_q + 4'd1;  // wraps 15 -> 0
    end

    assign err_d = accept && !one_hot;

    // ---------------------------------------------------------------------------
    // Command buffer
    // ---------------------------------------------------------------------------
    cmd_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (word),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // No pass-through when full: a pop this cycle does not open a slot early.
    assign cmd_ready = !fifo_full;

    // ---------------------------------------------------------------------------
    // Output stage: one register holding the word on offer downstream
    // ---------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    tx_data_d = fifo_head;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tx_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        tx_data_d = fifo_head;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            tx_data_q <= '0;
            seq_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            seq_q     <= seq_d;
            err_q     <= err_d;
        end
    end

    assign tx_valid = (state_q == ST_HOLD);
    assign tx_data  = tx_data_q;
    assign seq      = seq_q;
    assign cmd_err  = err_q;

endmodule

// File: tb/tb_cmd_encoder.sv
module tb_cmd_encoder;

    localparam int Depth = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cv;
    logic        cmd_ready;
    logic [5:0]  stb;
    logic [7:0]  amt;
    logic        cmd_err;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tr;
    logic [3:0]  seq;

    always #5 clk = ~clk;

    cmd_encoder #(
        .DATA_WIDTH   (32),
        .AMOUNT_WIDTH (8),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cv),
        .cmd_ready (cmd_ready),
        .on        (stb[0]),
        .off       (stb[1]),
        .increase  (stb[2]),
        .decrease  (stb[3]),
        .send      (stb[4]),
        .receive   (stb[5]),
        .amount    (amt),
        .cmd_err   (cmd_err),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tr),
        .seq       (seq)
    );

    int nvec  = 0;
    int nfail = 0;

    // Reference model: queue of buffered words plus the word on offer.
    logic [31:0] mq[$];
    logic        m_hold;
    logic [31:0] m_data;
    int          m_seq;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Word built from the field rules with plain arithmetic.
    function automatic logic [31:0] ref_word(input int op, input int a, input int sq);
        int b3, b2, b1;
        b3 = op * 16 + a / 16;
        b2 = (a % 16) * 16 + sq;
        b1 = 0;
        return 32'(op * 268435456 + a * 1048576 + sq * 65536 + (b3 ^ b2 ^ b1));
    endfunction

    function automatic logic [5:0] rand_onehot();
        logic [5:0] v;
        v = 6'd1 << $urandom_range(5, 0);
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hold = 1'b0;
        m_data = '0;
        m_seq  = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ":cmd_ready"}, {31'b0, cmd_ready}, {31'b0, (mq.size() < Depth)});
        chk({ctx, ":tx_valid"}, {31'b0, tx_valid}, {31'b0, m_hold});
        if (m_hold) chk({ctx, ":tx_data"}, tx_data, m_data);
        chk({ctx, ":seq"}, {28'b0, seq}, 32'(m_seq));
        chk({ctx, ":cmd_err"}, {31'b0, cmd_err}, {31'b0, m_err});
    endtask

    // Advance the model by one edge using the current inputs, clock the DUT, compare.
    task automatic step(input string ctx);
        bit acc, good;
        acc   = cv && (mq.size() < Depth);
        good  = ($countones(stb) == 1);
        m_err = acc && !good;
        if (!m_hold || tr) begin
            if (mq.size() > 0) begin
                m_data = mq.pop_front();
                m_hold = 1'b1;
            end else begin
                m_hold = 1'b0;
            end
        end
        if (acc && good) begin
            for (int i = 0; i < 6; i++)
                if (stb[i]) mq.push_back(ref_word(i + 1, int'(amt), m_seq));
            m_seq = (m_seq + 1) % 16;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(ctx);
    endtask

    task automatic do_reset(input string ctx);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk({ctx, ":rst_tx_valid"}, {31'b0, tx_valid}, 32'd0);
        chk({ctx, ":rst_tx_data"}, tx_data, 32'd0);
        chk({ctx, ":rst_cmd_err"}, {31'b0, cmd_err}, 32'd0);
        chk({ctx, ":rst_seq"}, {28'b0, seq}, 32'd0);
        chk({ctx, ":rst_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        cv    = 1'b0;
        stb   = '0;
        amt   = '0;
        tr    = 1'b0;
        model_reset();

        // Reset state and first command
        do_reset("init");
        cv = 1'b1; stb = 6'b000001; amt = 8'h5A; tr = 1'b1;
        step("first_push");
        cv = 1'b0; stb = '0;
        step("first_out");
        chk("first_word_const", tx_data, 32'h15A0_00B5);
        chk("first_seq_const", {28'b0, seq}, 32'd1);
        step("first_drain");

        // Malformed commands: two strobes, then none
        cv = 1'b1; stb = 6'b000011; amt = 8'h33;
        step("err_two");
        chk("err_two_pulse", {31'b0, cmd_err}, 32'd1);
        cv = 1'b0; stb = '0;
        step("err_two_after");
        cv = 1'b1; stb = 6'b000000;
        step("err_none");
        cv = 1'b0;
        step("err_none_after");
        chk("err_pulse_ends", {31'b0, cmd_err}, 32'd0);

        // Backpressure: fill FIFO plus output register, then drain in order
        do_reset("bp");
        tr = 1'b0;
        for (int i = 0; i < Depth + 1; i++) begin
            cv = 1'b1; stb = rand_onehot(); amt = 8'(17 * i + 3);
            step("bp_fill");
        end
        chk("bp_ready_low", {31'b0, cmd_ready}, 32'd0);
        stb = 6'b000100; amt = 8'hEE;
        step("bp_reject");
        cv = 1'b0;
        for (int i = 0; i < 3; i++) step("bp_stall");
        tr = 1'b1;
        k = 0;
        for (int i = 0; i < Depth + 3; i++) begin
            if (m_hold) begin
                chk("bp_drain_seq", {28'b0, tx_data[19:16]}, 32'(k));
                k++;
            end
            step("bp_drain");
        end
        chk("bp_drained_count", 32'(k), 32'(Depth + 1));

        // Sequence wrap with sustained throughput
        do_reset("wrap");
        tr = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cv  = (i < 17);
            stb = rand_onehot();
            amt = 8'($urandom);
            step("wrap");
            if (m_hold) begin
                chk("wrap_seq_field", {28'b0, tx_data[19:16]}, 32'(k % 16));
                k++;
            end
        end
        chk("wrap_word_count", 32'(k), 32'd17);

        // Reset in the middle of a drain
        do_reset("mid");
        tr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cv = 1'b1; stb = rand_onehot(); amt = 8'($urandom);
            step("mid_fill");
        end
        cv = 1'b0; tr = 1'b1;
        step("mid_drain");
        do_reset("mid_rst");
        for (int i = 0; i < 3; i++) step("mid_idle");
        cv = 1'b1; stb = 6'b100000; amt = 8'h81;
        step("mid_push");
        cv = 1'b0;
        step("mid_out");
        chk("mid_fresh_word", tx_data, ref_word(6, 8'h81, 0));

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cv  = ($urandom_range(3, 0) != 0);
            stb = ($urandom_range(9, 0) < 8) ? rand_onehot() : 6'($urandom);
            amt = 8'($urandom);
            tr  = ($urandom_range(9, 0) < 7);
            step("rand");
        end
        cv = 1'b0; tr = 1'b1;
        for (int i = 0; i < Depth + 3; i++) step("rand_flush");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
